// File: rtl/palette_ram_ctrl_if.sv
// rtl/palette_ram_ctrl_if.sv - video, download, ROM and status signals of the custom palette RAM
interface palette_ram_ctrl_if #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 15
);
  logic              pix_ce_n;
  logic [IDX_W-1:0]  color;
  logic [DATA_W-1:0] pixel;
  logic              dl_active;
  logic              dl_wr;
  logic [7:0]        dl_addr;
  logic [7:0]        dl_data;
  logic              dl_wait;
  logic              init_req;
  logic [IDX_W-1:0]  rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              custom_valid;
  logic              overflow;

  modport master (
    output pix_ce_n, color, dl_active, dl_wr, dl_addr, dl_data, init_req, rom_data,
    input  pixel, dl_wait, rom_addr, busy, custom_valid, overflow
  );

  modport slave (
    input  pix_ce_n, color, dl_active, dl_wr, dl_addr, dl_data, init_req, rom_data,
    output pixel, dl_wait, rom_addr, busy, custom_valid, overflow
  );
endinterface

// File: rtl/palette_ram_ctrl.sv
// rtl/palette_ram_ctrl.sv - single-port custom palette RAM shared by video reads, downloads and ROM fill
module palette_ram_ctrl #(
  parameter int ENTRIES  = 64,
  parameter int DATA_W   = 15,
  parameter int DL_BYTES = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  palette_ram_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_LOAD} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ram_q [ENTRIES];
  logic [DATA_W-1:0]   pixel_q;
  logic [IDX_W-1:0]    rom_addr_q, rom_addr_d;
  logic [7:0]          lo_q, lo_d;
  logic                pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]    pend_idx_q, pend_idx_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [ENTRIES-1:0]  mask_q, mask_d;
  logic                custom_valid_q, custom_valid_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                dl_wait_q, dl_wait_d;
  logic                dl_active_q;

  logic rd_slot;
  logic dl_rise;
  logic in_range;
  logic byte_ok;
  logic fill_wr;
  logic commit;
  logic fill_last;

  // Video reads own the port; fill and pending commits only use free cycles.
  assign rd_slot   = bus.pix_ce_n;
  assign dl_rise   = bus.dl_active & ~dl_active_q;
  assign in_range  = int'(bus.dl_addr) < DL_BYTES;
  assign fill_wr   = (state_q == S_FILL) & ~rd_slot & ~bus.init_req;
  assign commit    = (state_q != S_FILL) & pend_valid_q & ~rd_slot & ~bus.init_req;
  assign fill_last = rom_addr_q == IDX_W'(ENTRIES - 1);
  assign byte_ok   = bus.dl_wr & ~dl_wait_q & ~bus.init_req & in_range &
                     ((state_q == S_LOAD) | ((state_q == S_IDLE) & dl_rise));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.init_req) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL:  if (fill_wr && fill_last) state_d = S_IDLE;
        S_IDLE:  if (bus.dl_active) state_d = S_LOAD;
        // A word still pending at the end of a download commits before leaving LOAD.
        S_LOAD:  if (!bus.dl_active && !pend_valid_q) state_d = S_IDLE;
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    rom_addr_d     = rom_addr_q;
    lo_d           = lo_q;
    pend_valid_d   = pend_valid_q;
    pend_idx_d     = pend_idx_q;
    pend_data_d    = pend_data_q;
    mask_d         = mask_q;
    custom_valid_d = custom_valid_q;
    overflow_d     = overflow_q | (bus.dl_wr & dl_wait_q);
    if (bus.init_req) begin
      rom_addr_d     = '0;
      pend_valid_d   = 1'b0;
      mask_d         = '0;
      custom_valid_d = 1'b0;
    end else begin
      if (fill_wr) rom_addr_d = fill_last ? '0 : rom_addr_q + 1'b1;
      if (state_q == S_IDLE && bus.dl_active) mask_d = '0;
      if (commit) begin
        pend_valid_d       = 1'b0;
        mask_d[pend_idx_q] = 1'b1;
      end
      if (byte_ok) begin
        if (!bus.dl_addr[0]) begin
          lo_d = bus.dl_data;
        end else begin
          pend_valid_d = 1'b1;
          pend_idx_d   = bus.dl_addr[IDX_W:1];
          pend_data_d  = DATA_W'({bus.dl_data[6:0], lo_q});
        end
      end
      if (state_q == S_LOAD && state_d == S_IDLE) custom_valid_d = &mask_q;
    end
    busy_d    = state_d == S_FILL;
    dl_wait_d = busy_d | pend_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_q        <= '0;
      rom_addr_q     <= '0;
      lo_q           <= '0;
      pend_valid_q   <= 1'b0;
      pend_idx_q     <= '0;
      pend_data_q    <= '0;
      mask_q         <= '0;
      custom_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b1;
      dl_wait_q      <= 1'b1;
      dl_active_q    <= 1'b0;
    end else begin
      if (rd_slot) pixel_q <= ram_q[bus.color];
      rom_addr_q     <= rom_addr_d;
      lo_q           <= lo_d;
      pend_valid_q   <= pend_valid_d;
      pend_idx_q     <= pend_idx_d;
      pend_data_q    <= pend_data_d;
      mask_q         <= mask_d;
      custom_valid_q <= custom_valid_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      dl_wait_q      <= dl_wait_d;
      dl_active_q    <= bus.dl_active;
    end
  end

  // Palette storage has no reset; contents are only meaningful after a fill.
  always_ff @(posedge clk) begin
    if (fill_wr)     ram_q[rom_addr_q] <= bus.rom_data;
    else if (commit) ram_q[pend_idx_q] <= pend_data_q;
  end

  assign bus.pixel        = pixel_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.busy         = busy_q;
  assign bus.dl_wait      = dl_wait_q;
  assign bus.custom_valid = custom_valid_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_palette_ram_ctrl.sv
// tb/tb_palette_ram_ctrl.sv - randomized bench for palette_ram_ctrl against an entry-level palette model
module tb_palette_ram_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  palette_ram_ctrl_if bus ();
  palette_ram_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  function automatic logic [14:0] rom_val(input logic [5:0] a);
    return {a[2:0], a, a};
  endfunction

  assign bus.rom_data = rom_val(bus.rom_addr);

  logic [14:0] model_ram [64];
  logic [63:0] model_mask;
  logic [7:0]  model_lo;
  logic        model_ov;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_rom();
    for (int i = 0; i < 64; i++) model_ram[i] = rom_val(6'(i));
  endtask

  task automatic model_byte(input logic [7:0] addr, input logic [7:0] data);
    if (addr < 8'd128) begin
      if (!addr[0]) begin
        model_lo = data;
      end else begin
        model_ram[addr[6:1]]  = {data[6:0], model_lo};
        model_mask[addr[6:1]] = 1'b1;
      end
    end
  endtask

  task automatic video_read(input logic [5:0] idx, output logic [14:0] val);
    bus.pix_ce_n = 1'b1;
    bus.color    = idx;
    tick();
    val = bus.pixel;
    bus.pix_ce_n = 1'b0;
    repeat (7) tick();
  endtask

  task automatic check_read(input string tag, input logic [5:0] idx);
    logic [14:0] v;
    video_read(idx, v);
    check_eq(tag, 32'(v), 32'(model_ram[idx]));
  endtask

  task automatic raw_byte(input logic [7:0] addr, input logic [7:0] data);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = addr;
    bus.dl_data = data;
    tick();
    bus.dl_wr = 1'b0;
  endtask

  task automatic dl_byte(input logic [7:0] addr, input logic [7:0] data);
    int g = 0;
    while (bus.dl_wait && g < 16) begin
      tick();
      g++;
    end
    if (g >= 16) check_eq("dl_wait_timeout", 32'(bus.dl_wait), 32'd0);
    raw_byte(addr, data);
    model_byte(addr, data);
  endtask

  task automatic start_session();
    bus.dl_active = 1'b1;
    tick();
    model_mask = '0;
  endtask

  task automatic end_session(input string tag);
    bus.dl_active = 1'b0;
    repeat (4) tick();
    check_eq({tag, "_custom_valid"}, 32'(bus.custom_valid), 32'(&model_mask));
    check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'(model_ov));
  endtask

  task automatic wait_fill(input string tag, input int exp_cycles);
    int cnt = 0;
    while (bus.busy && cnt < 300) begin
      tick();
      cnt++;
    end
    check_eq(tag, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pixel"},    32'(bus.pixel), 32'd0);
    check_eq({tag, "_busy"},     32'(bus.busy), 32'd1);
    check_eq({tag, "_dl_wait"},  32'(bus.dl_wait), 32'd1);
    check_eq({tag, "_cv"},       32'(bus.custom_valid), 32'd0);
    check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    check_eq({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] v;
    logic [7:0]  d;
    logic [7:0]  a;
    logic [5:0]  idx;
    int          done;
    int          exp_len;
    int          writes;
    int          g;

    bus.pix_ce_n  = 1'b0;
    bus.color     = '0;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    bus.init_req  = 1'b0;
    model_mask    = '0;
    model_lo      = '0;
    model_ov      = 1'b0;
    reset_n       = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");

    // Fill after reset with a 1-in-16 video slot stealing RAM cycles.
    exp_len = 0;
    writes  = 0;
    while (writes < 64) begin
      if (exp_len % 16 != 3) writes++;
      exp_len++;
    end
    reset_n = 1'b1;
    done = 0;
    for (int c = 0; c < 300; c++) begin
      bus.pix_ce_n = (c % 16 == 3);
      bus.color    = 6'($urandom);
      tick();
      if (!bus.busy) begin
        done = c + 1;
        break;
      end
    end
    bus.pix_ce_n = 1'b0;
    check_eq("fill_len", 32'(done), 32'(exp_len));
    check_eq("fill_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_eq("fill_dl_wait", 32'(bus.dl_wait), 32'd0);
    repeat (8) tick();
    model_rom();
    video_read(6'h2A, v);
    check_eq("read_2a", 32'(v), 32'(rom_val(6'h2A)));
    for (int i = 0; i < 6; i++) check_read("fill_read", 6'($urandom));

    // Partial download; dl_active and the first byte rise together.
    model_mask    = '0;
    bus.dl_active = 1'b1;
    d = 8'($urandom);
    raw_byte(8'd0, d);
    model_byte(8'd0, d);
    for (int i = 1; i < 64; i++) dl_byte(8'(i), 8'($urandom));
    end_session("partial");
    check_read("partial_e0", 6'd0);
    for (int i = 0; i < 4; i++) begin
      idx = 6'($urandom_range(32, 63));
      video_read(idx, v);
      check_eq("partial_keep_rom", 32'(v), 32'(rom_val(idx)));
    end
    check_read("partial_low", 6'($urandom_range(0, 31)));

    // Full download, with a stray out-of-range odd byte midway.
    start_session();
    for (int i = 0; i < 128; i++) begin
      a = 8'(i);
      d = a[0] ? (8'h80 | (a >> 1)) : (a >> 1);
      dl_byte(a, d);
      if (i == 64) begin
        dl_byte(8'd201, 8'hFF);
        check_eq("oob_no_wait", 32'(bus.dl_wait), 32'd0);
      end
    end
    end_session("full");
    video_read(6'd5, v);
    check_eq("full_e5", 32'(v), 32'h0505);
    for (int i = 0; i < 6; i++) check_read("full_read", 6'($urandom));

    // Collision: video read in the cycle right after the odd byte.
    start_session();
    dl_byte(8'd6, 8'($urandom));
    d = 8'($urandom);
    raw_byte(8'd7, d);
    check_eq("coll_wait1", 32'(bus.dl_wait), 32'd1);
    bus.pix_ce_n = 1'b1;
    bus.color    = 6'd3;
    tick();
    bus.pix_ce_n = 1'b0;
    check_eq("coll_old", 32'(bus.pixel), 32'(model_ram[3]));
    check_eq("coll_wait2", 32'(bus.dl_wait), 32'd1);
    tick();
    check_eq("coll_wait_fall", 32'(bus.dl_wait), 32'd0);
    model_byte(8'd7, d);
    repeat (7) tick();
    end_session("coll");
    check_read("coll_new", 6'd3);

    // Violation: byte while dl_wait is high is dropped, later bytes still land.
    start_session();
    dl_byte(8'd8, 8'($urandom));
    dl_byte(8'd9, 8'($urandom));
    raw_byte(8'd13, 8'h33);
    model_ov = 1'b1;
    check_eq("viol_overflow", 32'(bus.overflow), 32'd1);
    dl_byte(8'd10, 8'($urandom));
    dl_byte(8'd11, 8'($urandom));
    end_session("viol");
    check_read("viol_e4", 6'd4);
    check_read("viol_e5", 6'd5);
    check_read("viol_e6", 6'd6);

    // Random download session over the full address range including ignored bytes.
    start_session();
    for (int i = 0; i < 40; i++) dl_byte(8'($urandom_range(0, 159)), 8'($urandom));
    end_session("rand");
    for (int i = 0; i < 8; i++) check_read("rand_read", 6'($urandom));

    // init_req mid-LOAD with a word pending.
    start_session();
    dl_byte(8'd20, 8'h5A);
    dl_byte(8'd21, 8'h7F);
    bus.init_req  = 1'b1;
    bus.dl_active = 1'b0;
    tick();
    bus.init_req = 1'b0;
    check_eq("init_busy", 32'(bus.busy), 32'd1);
    check_eq("init_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_eq("init_dl_wait", 32'(bus.dl_wait), 32'd1);
    check_eq("init_cv", 32'(bus.custom_valid), 32'd0);
    wait_fill("refill_len", 64);
    model_rom();
    for (int i = 0; i < 64; i++) check_read("refill_entry", 6'(i));

    // Reset asserted mid-fill at rom_addr 30.
    bus.init_req = 1'b1;
    tick();
    bus.init_req = 1'b0;
    g = 0;
    while (bus.rom_addr != 6'd30 && g < 100) begin
      tick();
      g++;
    end
    check_eq("reach_addr30", 32'(bus.rom_addr), 32'd30);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midfill_reset");
    tick();
    reset_n  = 1'b1;
    model_ov = 1'b0;
    wait_fill("post_reset_fill", 64);
    for (int i = 0; i < 8; i++) check_read("post_reset_read", 6'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
